// File: rtl/multi_alarm_if.sv
// Field-select codes plus the shared edit/control/status bundle of multi_alarm.
// The clock time inputs travel in the same bundle as the alarm controls.
`ifndef SELECT_SEC
`define SELECT_SEC  2'd0
`endif
`ifndef SELECT_MIN
`define SELECT_MIN  2'd1
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd2
`endif

interface multi_alarm_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = $clog2(NUM_ALARMS)
);
  logic [5:0]            sec_in;
  logic [5:0]            min_in;
  logic [4:0]            hour_in;
  logic [IDX_W-1:0]      alarm_sel;
  logic [1:0]            select;
  logic                  increment;
  logic                  decrement;
  logic                  arm_toggle;
  logic                  snooze;
  logic                  dismiss;
  logic [5:0]            sec_out;
  logic [5:0]            min_out;
  logic [4:0]            hour_out;
  logic [NUM_ALARMS-1:0] armed;
  logic [NUM_ALARMS-1:0] ringing;
  logic [NUM_ALARMS-1:0] snoozed;
  logic                  out;

  modport master (
    output sec_in, min_in, hour_in, alarm_sel, select,
           increment, decrement, arm_toggle, snooze, dismiss,
    input  sec_out, min_out, hour_out, armed, ringing, snoozed, out
  );

  modport slave (
    input  sec_in, min_in, hour_in, alarm_sel, select,
           increment, decrement, arm_toggle, snooze, dismiss,
    output sec_out, min_out, hour_out, armed, ringing, snoozed, out
  );
endinterface

// File: rtl/multi_alarm.sv
// Multi-channel alarm: per-channel arm/ring/snooze/timeout FSM driven by the running
// clock time, with one shared edit port for the alarm times.
module multi_alarm #(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZE       = 3,
  parameter int RING_TIMEOUT_SEC = 300,
  parameter int IDX_W            = $clog2(NUM_ALARMS)
) (
  input logic          clk,
  input logic          reset,
  multi_alarm_if.slave bus
);
  localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
  localparam int TO_W  = $clog2(RING_TIMEOUT_SEC + 1);

  typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZED} state_t;

  state_t           state_q [NUM_ALARMS];
  state_t           state_d [NUM_ALARMS];
  logic [5:0]       alarm_sec  [NUM_ALARMS];
  logic [5:0]       alarm_min  [NUM_ALARMS];
  logic [4:0]       alarm_hour [NUM_ALARMS];
  logic [5:0]       tgt_sec  [NUM_ALARMS];
  logic [5:0]       tgt_min  [NUM_ALARMS];
  logic [4:0]       tgt_hour [NUM_ALARMS];
  logic [SNZ_W-1:0] snz_cnt [NUM_ALARMS];
  logic [TO_W-1:0]  to_cnt  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match_latched;

  logic       inc_q, dec_q, arm_q, snz_q, dis_q;
  logic [5:0] sec_prev;
  logic       inc_edge, dec_edge, arm_edge, snz_edge, dis_edge;
  logic       edit_up, edit_dn, tick, sel_valid;
  logic [IDX_W-1:0] sel;
  logic [6:0] snz_min_sum;
  logic [5:0] snz_min;
  logic [4:0] snz_hour;
  logic [NUM_ALARMS-1:0] alarm_match, target_match, arm_hit, timed_out, snz_allowed;
  logic [NUM_ALARMS-1:0] armed_v, ringing_v, snoozed_v;

  // One history register per level input; sec_prev gives the one-cycle second tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      arm_q    <= 1'b0;
      snz_q    <= 1'b0;
      dis_q    <= 1'b0;
      sec_prev <= '0;
    end else begin
      inc_q    <= bus.increment;
      dec_q    <= bus.decrement;
      arm_q    <= bus.arm_toggle;
      snz_q    <= bus.snooze;
      dis_q    <= bus.dismiss;
      sec_prev <= bus.sec_in;
    end
  end

  assign inc_edge  = bus.increment  & ~inc_q;
  assign dec_edge  = bus.decrement  & ~dec_q;
  assign arm_edge  = bus.arm_toggle & ~arm_q;
  assign snz_edge  = bus.snooze     & ~snz_q;
  assign dis_edge  = bus.dismiss    & ~dis_q;
  assign edit_up   = inc_edge & ~dec_edge;
  assign edit_dn   = dec_edge & ~inc_edge;
  assign tick      = bus.sec_in != sec_prev;
  assign sel       = bus.alarm_sel;
  assign sel_valid = int'(sel) < NUM_ALARMS;

  // Snooze target is shared by all channels: now + SNOOZE_MIN minutes, seconds kept.
  always_comb begin
    snz_min_sum = {1'b0, bus.min_in} + 7'(SNOOZE_MIN);
    snz_min     = snz_min_sum[5:0];
    snz_hour    = bus.hour_in;
    if (snz_min_sum >= 7'd60) begin
      snz_min  = 6'(snz_min_sum - 7'd60);
      snz_hour = (bus.hour_in == 5'd23) ? 5'd0 : bus.hour_in + 5'd1;
    end
  end

  always_comb begin
    alarm_match  = '0;
    target_match = '0;
    arm_hit      = '0;
    timed_out    = '0;
    snz_allowed  = '0;
    for (int ch = 0; ch < NUM_ALARMS; ch++) begin
      alarm_match[ch]  = {bus.hour_in, bus.min_in, bus.sec_in} ==
                         {alarm_hour[ch], alarm_min[ch], alarm_sec[ch]};
      target_match[ch] = {bus.hour_in, bus.min_in, bus.sec_in} ==
                         {tgt_hour[ch], tgt_min[ch], tgt_sec[ch]};
      arm_hit[ch]      = arm_edge & sel_valid & (int'(sel) == ch);
      timed_out[ch]    = int'(to_cnt[ch]) >= RING_TIMEOUT_SEC;
      snz_allowed[ch]  = int'(snz_cnt[ch]) < MAX_SNOOZE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_ALARMS; ch++) state_q[ch] <= DISARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority: arm_toggle > dismiss > snooze > timeout > match.
  always_comb begin
    for (int ch = 0; ch < NUM_ALARMS; ch++) begin
      state_d[ch] = state_q[ch];
      if (arm_hit[ch]) begin
        state_d[ch] = (state_q[ch] == DISARMED) ? ARMED : DISARMED;
      end else begin
        case (state_q[ch])
          ARMED: begin
            if (alarm_match[ch] && !match_latched[ch]) state_d[ch] = RINGING;
          end
          RINGING: begin
            if (dis_edge)           state_d[ch] = ARMED;
            else if (snz_edge)      state_d[ch] = snz_allowed[ch] ? SNOOZED : ARMED;
            else if (timed_out[ch]) state_d[ch] = ARMED;
          end
          SNOOZED: begin
            if (dis_edge)              state_d[ch] = ARMED;
            else if (target_match[ch]) state_d[ch] = RINGING;
          end
          default: ;
        endcase
      end
    end
  end

  // match_latched blocks an immediate re-ring while the clock still sits on the alarm time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_ALARMS; ch++) begin
        alarm_sec[ch]  <= '0;
        alarm_min[ch]  <= '0;
        alarm_hour[ch] <= '0;
        tgt_sec[ch]    <= '0;
        tgt_min[ch]    <= '0;
        tgt_hour[ch]   <= '0;
        snz_cnt[ch]    <= '0;
        to_cnt[ch]     <= '0;
      end
      match_latched <= '0;
    end else begin
      for (int ch = 0; ch < NUM_ALARMS; ch++) begin
        if (sel_valid && int'(sel) == ch && (edit_up || edit_dn)) begin
          case (bus.select)
            `SELECT_SEC:
              if (edit_up) alarm_sec[ch] <= (alarm_sec[ch] == 6'd59) ? 6'd0 : alarm_sec[ch] + 6'd1;
              else         alarm_sec[ch] <= (alarm_sec[ch] == 6'd0) ? 6'd59 : alarm_sec[ch] - 6'd1;
            `SELECT_MIN:
              if (edit_up) alarm_min[ch] <= (alarm_min[ch] == 6'd59) ? 6'd0 : alarm_min[ch] + 6'd1;
              else         alarm_min[ch] <= (alarm_min[ch] == 6'd0) ? 6'd59 : alarm_min[ch] - 6'd1;
            `SELECT_HOUR:
              if (edit_up) alarm_hour[ch] <= (alarm_hour[ch] == 5'd23) ? 5'd0 : alarm_hour[ch] + 5'd1;
              else         alarm_hour[ch] <= (alarm_hour[ch] == 5'd0) ? 5'd23 : alarm_hour[ch] - 5'd1;
            default: ;
          endcase
        end

        if (state_q[ch] == ARMED && state_d[ch] == RINGING) begin
          snz_cnt[ch] <= '0;
          to_cnt[ch]  <= '0;
        end else if (state_q[ch] == SNOOZED && state_d[ch] == RINGING) begin
          to_cnt[ch] <= '0;
        end else if (state_q[ch] == RINGING && state_d[ch] == RINGING && tick && !timed_out[ch]) begin
          to_cnt[ch] <= to_cnt[ch] + TO_W'(1);
        end

        if (state_q[ch] == RINGING && state_d[ch] == SNOOZED) begin
          tgt_sec[ch]  <= bus.sec_in;
          tgt_min[ch]  <= snz_min;
          tgt_hour[ch] <= snz_hour;
          snz_cnt[ch]  <= snz_cnt[ch] + SNZ_W'(1);
        end

        if (!alarm_match[ch])
          match_latched[ch] <= 1'b0;
        else if (state_q[ch] == ARMED && state_d[ch] == RINGING)
          match_latched[ch] <= 1'b1;
      end
    end
  end

  always_comb begin
    armed_v   = '0;
    ringing_v = '0;
    snoozed_v = '0;
    for (int ch = 0; ch < NUM_ALARMS; ch++) begin
      armed_v[ch]   = state_q[ch] != DISARMED;
      ringing_v[ch] = state_q[ch] == RINGING;
      snoozed_v[ch] = state_q[ch] == SNOOZED;
    end
  end

  assign bus.armed    = armed_v;
  assign bus.ringing  = ringing_v;
  assign bus.snoozed  = snoozed_v;
  assign bus.out      = |ringing_v;
  assign bus.sec_out  = sel_valid ? alarm_sec[sel]  : 6'd0;
  assign bus.min_out  = sel_valid ? alarm_min[sel]  : 6'd0;
  assign bus.hour_out = sel_valid ? alarm_hour[sel] : 5'd0;
endmodule

// File: tb/tb_multi_alarm.sv
// Bench for multi_alarm: directed scenarios plus random traffic, every cycle compared
// against a seconds-of-day behavioural model of the alarm channels.
`ifndef SELECT_SEC
`define SELECT_SEC  2'd0
`endif
`ifndef SELECT_MIN
`define SELECT_MIN  2'd1
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd2
`endif

module tb_multi_alarm;
  localparam int N    = 5;
  localparam int SNZM = 5;
  localparam int MAXS = 3;
  localparam int TOUT = 3;
  localparam int DAY  = 86400;
  localparam int S_DIS = 0, S_ARM = 1, S_RNG = 2, S_SNZ = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  multi_alarm_if #(.NUM_ALARMS(N)) bus ();

  multi_alarm #(
    .NUM_ALARMS(N), .SNOOZE_MIN(SNZM), .MAX_SNOOZE(MAXS), .RING_TIMEOUT_SEC(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state: alarm and snooze target held as seconds of the day.
  int m_mode [N];
  int m_alarm [N];
  int m_target [N];
  int m_cnt [N];
  int m_to [N];
  bit m_guard [N];
  bit h_inc, h_dec, h_arm, h_snz, h_dis;
  int prev_sec;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edit(input int ch, input int d, input logic [1:0] fsel);
    int h, m, s;
    h = m_alarm[ch] / 3600;
    m = (m_alarm[ch] / 60) % 60;
    s = m_alarm[ch] % 60;
    case (fsel)
      `SELECT_SEC:  s = (s + d + 60) % 60;
      `SELECT_MIN:  m = (m + d + 60) % 60;
      `SELECT_HOUR: h = (h + d + 24) % 24;
      default: ;
    endcase
    m_alarm[ch] = h * 3600 + m * 60 + s;
  endtask

  task automatic model_update();
    bit e_inc, e_dec, e_arm, e_snz, e_dis, tk, sel_ok, match;
    int now, sel;
    if (!reset) begin
      for (int ch = 0; ch < N; ch++) begin
        m_mode[ch] = S_DIS; m_alarm[ch] = 0; m_target[ch] = 0;
        m_cnt[ch] = 0; m_to[ch] = 0; m_guard[ch] = 0;
      end
      {h_inc, h_dec, h_arm, h_snz, h_dis} = '0;
      prev_sec = 0;
      return;
    end
    e_inc = bus.increment && !h_inc;
    e_dec = bus.decrement && !h_dec;
    e_arm = bus.arm_toggle && !h_arm;
    e_snz = bus.snooze && !h_snz;
    e_dis = bus.dismiss && !h_dis;
    h_inc = bus.increment; h_dec = bus.decrement; h_arm = bus.arm_toggle;
    h_snz = bus.snooze; h_dis = bus.dismiss;
    tk = int'(bus.sec_in) != prev_sec;
    prev_sec = int'(bus.sec_in);
    now = int'(bus.hour_in) * 3600 + int'(bus.min_in) * 60 + int'(bus.sec_in);
    sel = int'(bus.alarm_sel);
    sel_ok = sel < N;
    for (int ch = 0; ch < N; ch++) begin
      match = (now == m_alarm[ch]);
      if (e_arm && sel_ok && sel == ch) begin
        m_mode[ch] = (m_mode[ch] == S_DIS) ? S_ARM : S_DIS;
      end else if (m_mode[ch] == S_RNG) begin
        if (e_dis) m_mode[ch] = S_ARM;
        else if (e_snz) begin
          if (m_cnt[ch] < MAXS) begin
            m_mode[ch] = S_SNZ;
            m_target[ch] = (now + SNZM * 60) % DAY;
            m_cnt[ch]++;
          end else m_mode[ch] = S_ARM;
        end else if (m_to[ch] >= TOUT) m_mode[ch] = S_ARM;
        else if (tk) m_to[ch]++;
      end else if (m_mode[ch] == S_SNZ) begin
        if (e_dis) m_mode[ch] = S_ARM;
        else if (now == m_target[ch]) begin
          m_mode[ch] = S_RNG;
          m_to[ch] = 0;
        end
      end else if (m_mode[ch] == S_ARM) begin
        if (match && !m_guard[ch]) begin
          m_mode[ch] = S_RNG; m_cnt[ch] = 0; m_to[ch] = 0; m_guard[ch] = 1;
        end
      end
      if (!match) m_guard[ch] = 0;
      if (sel_ok && sel == ch && (e_inc != e_dec)) model_edit(ch, e_inc ? 1 : -1, bus.select);
    end
  endtask

  task automatic check_output();
    logic [N-1:0] ea, er, es;
    int sel, t;
    ea = '0; er = '0; es = '0;
    for (int ch = 0; ch < N; ch++) begin
      ea[ch] = m_mode[ch] != S_DIS;
      er[ch] = m_mode[ch] == S_RNG;
      es[ch] = m_mode[ch] == S_SNZ;
    end
    sel = int'(bus.alarm_sel);
    t = (sel < N) ? m_alarm[sel] : 0;
    check("armed", int'(bus.armed), int'(ea));
    check("ringing", int'(bus.ringing), int'(er));
    check("snoozed", int'(bus.snoozed), int'(es));
    check("out", int'(bus.out), int'(|er));
    check("sec_out", int'(bus.sec_out), t % 60);
    check("min_out", int'(bus.min_out), (t / 60) % 60);
    check("hour_out", int'(bus.hour_out), t / 3600);
  endtask

  always @(posedge clk) begin
    model_update();
    #1;
    check_output();
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.hour_in = 5'(h); bus.min_in = 6'(m); bus.sec_in = 6'(s);
    step();
  endtask

  task automatic set_tod(input int t);
    set_time(t / 3600, (t / 60) % 60, t % 60);
  endtask

  // which: 0 inc, 1 dec, 2 arm_toggle, 3 snooze, 4 dismiss
  task automatic pulse(input int which, input int n = 1);
    repeat (n) begin
      case (which)
        0: bus.increment = 1'b1;
        1: bus.decrement = 1'b1;
        2: bus.arm_toggle = 1'b1;
        3: bus.snooze = 1'b1;
        default: bus.dismiss = 1'b1;
      endcase
      step();
      {bus.increment, bus.decrement, bus.arm_toggle, bus.snooze, bus.dismiss} = '0;
      step();
    end
  endtask

  task automatic apply_stimulus(input int cycles);
    int t, r, ch, targ;
    t = int'(bus.hour_in) * 3600 + int'(bus.min_in) * 60 + int'(bus.sec_in);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 7) == 0) bus.increment  = ~bus.increment;
      if ($urandom_range(0, 7) == 0) bus.decrement  = ~bus.decrement;
      if ($urandom_range(0, 11) == 0) bus.arm_toggle = ~bus.arm_toggle;
      if ($urandom_range(0, 9) == 0) bus.snooze     = ~bus.snooze;
      if ($urandom_range(0, 13) == 0) bus.dismiss    = ~bus.dismiss;
      if ($urandom_range(0, 3) == 0) bus.alarm_sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) bus.select     = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      ch = $urandom_range(0, N - 1);
      targ = ($urandom_range(0, 1) == 0) ? m_alarm[ch] : m_target[ch];
      if (r >= 5 && r <= 7) t = (t + 1) % DAY;
      else if (r == 8) t = targ;
      else if (r == 9) t = (targ + DAY - 1) % DAY;
      bus.hour_in = 5'(t / 3600); bus.min_in = 6'((t / 60) % 60); bus.sec_in = 6'(t % 60);
      step();
    end
  endtask

  initial begin
    int t0, t;
    bus.sec_in = '0; bus.min_in = '0; bus.hour_in = '0;
    bus.alarm_sel = '0; bus.select = `SELECT_SEC;
    {bus.increment, bus.decrement, bus.arm_toggle, bus.snooze, bus.dismiss} = '0;
    #2 reset = 1'b0;
    step(3);
    reset = 1'b1;
    step();
    check("reset armed", int'(bus.armed), 0);
    check("reset ringing", int'(bus.ringing), 0);
    check("reset out", int'(bus.out), 0);
    check("reset time", int'({bus.hour_out, bus.min_out, bus.sec_out}), 0);

    // Held increment on minutes fires once.
    bus.select = `SELECT_MIN; bus.increment = 1'b1;
    step(3);
    bus.increment = 1'b0;
    step();
    check("held inc min", int'(bus.min_out), 1);
    check("held inc sec", int'(bus.sec_out), 0);

    // Hour wrap on channel 2, channel 0 untouched.
    bus.alarm_sel = 3'd2; bus.select = `SELECT_HOUR;
    pulse(1);
    check("hour dec wrap", int'(bus.hour_out), 23);
    pulse(0);
    check("hour inc wrap", int'(bus.hour_out), 0);
    pulse(1);
    check("hour dec again", int'(bus.hour_out), 23);
    bus.increment = 1'b1; bus.decrement = 1'b1;
    step();
    bus.increment = 1'b0; bus.decrement = 1'b0;
    step();
    check("inc+dec hold", int'(bus.hour_out), 23);
    bus.alarm_sel = 3'd0;
    step();
    check("ch0 min kept", int'(bus.min_out), 1);
    check("ch0 hour kept", int'(bus.hour_out), 0);

    // Out-of-range select ignores edits and arming.
    bus.alarm_sel = 3'd6;
    pulse(0);
    pulse(2);
    check("oor sec_out", int'(bus.sec_out), 0);
    check("oor armed", int'(bus.armed), 0);

    // Channel 1 at 07:30:00: ring, dismiss, no re-ring.
    bus.alarm_sel = 3'd1; bus.select = `SELECT_HOUR;
    pulse(0, 7);
    bus.select = `SELECT_MIN;
    pulse(0, 30);
    pulse(2);
    check("ch1 armed", int'(bus.armed), 5'b00010);
    check("ch1 min", int'(bus.min_out), 30);
    set_time(7, 29, 59);
    check("pre-match", int'(bus.ringing), 0);
    set_time(7, 30, 0);
    check("ch1 ringing", int'(bus.ringing), 5'b00010);
    check("ch1 out", int'(bus.out), 1);
    bus.dismiss = 1'b1;
    step();
    bus.dismiss = 1'b0;
    check("dismissed", int'(bus.ringing), 0);
    check("still armed", int'(bus.armed), 5'b00010);
    step(4);
    check("no re-ring", int'(bus.ringing), 0);

    // Channel 3 at 23:58:10: snooze chain across midnight.
    bus.alarm_sel = 3'd3; bus.select = `SELECT_HOUR;
    pulse(1);
    bus.select = `SELECT_MIN;
    pulse(1, 2);
    bus.select = `SELECT_SEC;
    pulse(0, 10);
    pulse(2);
    check("ch3 armed", int'(bus.armed), 5'b01010);
    t0 = 23 * 3600 + 58 * 60 + 10;
    set_tod(t0 - 1);
    set_tod(t0);
    check("ch3 ringing", int'(bus.ringing), 5'b01000);
    for (int k = 1; k <= MAXS; k++) begin
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      check("snoozed", int'(bus.snoozed), 5'b01000);
      t = (t0 + k * SNZM * 60) % DAY;
      set_tod(t - 1);
      check("snooze wait", int'(bus.ringing), 0);
      set_tod(t);
      check("snooze re-ring", int'(bus.ringing), 5'b01000);
    end
    check("target 00:13:10", int'(bus.min_in), 13);
    bus.snooze = 1'b1;
    step();
    bus.snooze = 1'b0;
    check("4th snooze ring", int'(bus.ringing), 0);
    check("4th snooze snz", int'(bus.snoozed), 0);
    check("4th snooze armed", int'(bus.armed), 5'b01010);

    // Timeout after three second ticks, none while seconds are static.
    set_tod(t0 - 1);
    set_tod(t0);
    step(10);
    check("static no timeout", int'(bus.ringing), 5'b01000);
    set_tod(t0 + 1);
    set_tod(t0 + 2);
    set_tod(t0 + 3);
    check("before timeout", int'(bus.ringing), 5'b01000);
    step();
    check("timed out", int'(bus.ringing), 0);
    check("timeout armed", int'(bus.armed), 5'b01010);

    // arm_toggle wins over a match on the same cycle.
    set_time(7, 29, 59);
    bus.alarm_sel = 3'd1; bus.arm_toggle = 1'b1;
    set_time(7, 30, 0);
    bus.arm_toggle = 1'b0;
    check("toggle vs match armed", int'(bus.armed), 5'b01000);
    check("toggle vs match ring", int'(bus.ringing), 0);

    // Snooze and dismiss together dismiss.
    set_tod(t0 - 1);
    set_tod(t0);
    bus.snooze = 1'b1; bus.dismiss = 1'b1;
    step();
    bus.snooze = 1'b0; bus.dismiss = 1'b0;
    check("snz+dis ring", int'(bus.ringing), 0);
    check("snz+dis snz", int'(bus.snoozed), 0);
    check("snz+dis armed", int'(bus.armed), 5'b01000);

    // Two channels sharing 07:30:00 ring together and one dismiss clears both.
    bus.alarm_sel = 3'd4; bus.select = `SELECT_HOUR;
    pulse(0, 7);
    bus.select = `SELECT_MIN;
    pulse(0, 30);
    pulse(2);
    bus.alarm_sel = 3'd1;
    pulse(2);
    check("pair armed", int'(bus.armed), 5'b11010);
    set_time(7, 29, 59);
    set_time(7, 30, 0);
    check("pair ringing", int'(bus.ringing), 5'b10010);
    bus.dismiss = 1'b1;
    step();
    bus.dismiss = 1'b0;
    check("pair dismissed", int'(bus.ringing), 0);
    step();

    apply_stimulus(3000);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
